// File: rtl/algn_irq_pkg.sv
// -----------------------------------------------------------------------------
// algn_irq_pkg
// Shared constants and types for the alignment controller interrupt/status
// block. The status vector layout is defined once here so the RTL, the
// register block and the bench all agree on bit positions.
// -----------------------------------------------------------------------------
package algn_irq_pkg;

  localparam int NUM_STATUS   = 5;

  localparam int STS_MAX_DROP = 0;
  localparam int STS_RX_FULL  = 1;
  localparam int STS_RX_EMPTY = 2;
  localparam int STS_TX_FULL  = 3;
  localparam int STS_TX_EMPTY = 4;

  typedef logic [NUM_STATUS-1:0] algn_status_t;

endpackage

// File: rtl/algn_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// algn_irq_ctrl_if
// Bundles the datapath strobes, the register-block controls and the status
// outputs of algn_irq_ctrl.
//   master : datapath / register block side (drives strobes, irq_en, status_clr)
//   slave  : algn_irq_ctrl side (drives status, levels, proto_err, irq)
// -----------------------------------------------------------------------------
interface algn_irq_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  import algn_irq_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             rx_fifo_push;
  logic             rx_fifo_pop;
  logic             tx_fifo_push;
  logic             tx_fifo_pop;
  logic             max_drop;
  algn_status_t     irq_en;
  algn_status_t     status_clr;
  algn_status_t     status;
  logic [CNT_W-1:0] rx_lvl;
  logic [CNT_W-1:0] tx_lvl;
  logic             proto_err;
  logic             irq;

  modport master (
    output rx_fifo_push, rx_fifo_pop, tx_fifo_push, tx_fifo_pop, max_drop,
    output irq_en, status_clr,
    input  status, rx_lvl, tx_lvl, proto_err, irq
  );

  modport slave (
    input  rx_fifo_push, rx_fifo_pop, tx_fifo_push, tx_fifo_pop, max_drop,
    input  irq_en, status_clr,
    output status, rx_lvl, tx_lvl, proto_err, irq
  );

endinterface

// File: rtl/algn_fifo_lvl_tracker.sv
// -----------------------------------------------------------------------------
// algn_fifo_lvl_tracker
// Mirrors the fill level of one FIFO from its push/pop strobes and flags the
// transitions onto the full and empty boundaries.
//   clk, reset      : clock, async active-high reset
//   push, pop       : FIFO write / read strobes
//   lvl             : registered fill level (0..FIFO_DEPTH)
//   full_evt        : level moves onto FIFO_DEPTH at this edge (combinational)
//   empty_evt       : level moves onto 0 at this edge (combinational)
//   err             : push at full or pop at empty this cycle (combinational)
// -----------------------------------------------------------------------------
module algn_fifo_lvl_tracker #(
  parameter  int FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] lvl,
  output logic             full_evt,
  output logic             empty_evt,
  output logic             err
);

  localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] lvl_q;
  logic [CNT_W-1:0] lvl_d;

  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    lvl_d = lvl_q;
    err   = 1'b0;
    // push & pop together leaves the level alone, even at a boundary.
    if (push && !pop) begin
      if (lvl_q == LVL_MAX) err   = 1'b1;
      else                  lvl_d = lvl_q + CNT_W'(1);
    end else if (pop && !push) begin
      if (lvl_q == '0)      err   = 1'b1;
      else                  lvl_d = lvl_q - CNT_W'(1);
    end
  end

  // Events fire only on arrival at a boundary, never while sitting on one.
  assign full_evt  = (lvl_d == LVL_MAX) && (lvl_q != LVL_MAX);
  assign empty_evt = (lvl_d == '0)      && (lvl_q != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lvl_q <= '0;
    else       lvl_q <= lvl_d;
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/algn_irq_ctrl.sv
// -----------------------------------------------------------------------------
// algn_irq_ctrl
// Interrupt and status controller for the alignment controller. Tracks RX/TX
// FIFO levels, turns full/empty transitions and max_drop pulses into sticky
// write-1-to-clear status bits, and drives one registered irq.
//   clk, reset : clock, async active-high reset
//   bus        : algn_irq_ctrl_if slave modport (strobes, irq_en, status_clr
//                in; status, rx_lvl, tx_lvl, proto_err, irq out)
// -----------------------------------------------------------------------------
module algn_irq_ctrl
  import algn_irq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  algn_irq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0] rx_lvl;
  logic [CNT_W-1:0] tx_lvl;
  logic             rx_full_evt, rx_empty_evt, rx_err;
  logic             tx_full_evt, tx_empty_evt, tx_err;

  algn_status_t     evt;
  algn_status_t     status_q;
  logic             proto_err_q;
  logic             irq_q;

  algn_fifo_lvl_tracker #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_trk (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.rx_fifo_push),
    .pop       (bus.rx_fifo_pop),
    .lvl       (rx_lvl),
    .full_evt  (rx_full_evt),
    .empty_evt (rx_empty_evt),
    .err       (rx_err)
  );

  algn_fifo_lvl_tracker #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_trk (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.tx_fifo_push),
    .pop       (bus.tx_fifo_pop),
    .lvl       (tx_lvl),
    .full_evt  (tx_full_evt),
    .empty_evt (tx_empty_evt),
    .err       (tx_err)
  );

  always_comb begin
    evt               = '0;
    evt[STS_MAX_DROP] = bus.max_drop;
    evt[STS_RX_FULL]  = rx_full_evt;
    evt[STS_RX_EMPTY] = rx_empty_evt;
    evt[STS_TX_FULL]  = tx_full_evt;
    evt[STS_TX_EMPTY] = tx_empty_evt;
  end

  // Set wins over a same-cycle clear. irq looks at the registered status, so
  // it trails status by exactly one edge, and irq_en only gates the irq path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q    <= '0;
      proto_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      status_q    <= evt | (status_q & ~bus.status_clr);
      proto_err_q <= proto_err_q | rx_err | tx_err;
      irq_q       <= |(status_q & bus.irq_en);
    end
  end

  assign bus.status    = status_q;
  assign bus.rx_lvl    = rx_lvl;
  assign bus.tx_lvl    = tx_lvl;
  assign bus.proto_err = proto_err_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_algn_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_algn_irq_ctrl
// Self-checking bench for algn_irq_ctrl: a constant vector table for the RX
// full scenario, hand-written corner sequences, and a randomized run checked
// against a level/status reference model built on plain integers.
// -----------------------------------------------------------------------------
module tb_algn_irq_ctrl;
  import algn_irq_pkg::*;

  localparam int D = 8;

  logic clk;
  logic reset;

  algn_irq_ctrl_if #(.FIFO_DEPTH(D)) bus ();

  algn_irq_ctrl #(.FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  int           m_rx, m_tx;
  bit [4:0]     m_sts;
  bit           m_err, m_irq;

  typedef struct {
    bit       rp, rpo, tp, tpo, drop;
    bit [4:0] en, clr;
    int       rx, tx;
    bit [4:0] sts;
    bit       err, irq;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rx = 0; m_tx = 0; m_sts = '0; m_err = 0; m_irq = 0;
  endfunction

  // One FIFO: the level moves by one unless it would leave 0..D; an event is
  // the level landing on a boundary it was not already on.
  function automatic void model_fifo(input bit push, input bit pop, inout int lvl,
                                     output bit full_ev, output bit empty_ev);
    full_ev = 0; empty_ev = 0;
    if (push && !pop) begin
      if (lvl == D) m_err = 1;
      else begin lvl++; full_ev = (lvl == D); end
    end else if (pop && !push) begin
      if (lvl == 0) m_err = 1;
      else begin lvl--; empty_ev = (lvl == 0); end
    end
  endfunction

  function automatic void model_step(input bit rp, rpo, tp, tpo, drop,
                                     input bit [4:0] en, clr);
    bit [4:0] ev;
    bit rf, re, tf, te;
    m_irq = ((m_sts & en) != 0);
    model_fifo(rp, rpo, m_rx, rf, re);
    model_fifo(tp, tpo, m_tx, tf, te);
    ev = {te, tf, re, rf, drop};
    m_sts = ev | (m_sts & ~clr);
  endfunction

  task automatic step(input bit rp, rpo, tp, tpo, drop, input bit [4:0] en, clr,
                      input string tag);
    bus.rx_fifo_push = rp;  bus.rx_fifo_pop = rpo;
    bus.tx_fifo_push = tp;  bus.tx_fifo_pop = tpo;
    bus.max_drop     = drop;
    bus.irq_en       = en;  bus.status_clr  = clr;
    model_step(rp, rpo, tp, tpo, drop, en, clr);
    @(posedge clk);
    #1;
    check({tag, ".rx_lvl"},    32'(bus.rx_lvl),  32'(m_rx));
    check({tag, ".tx_lvl"},    32'(bus.tx_lvl),  32'(m_tx));
    check({tag, ".status"},    32'(bus.status),  32'(m_sts));
    check({tag, ".proto_err"}, 32'(bus.proto_err), 32'(m_err));
    check({tag, ".irq"},       32'(bus.irq),     32'(m_irq));
  endtask

  task automatic idle(input bit [4:0] en, input string tag);
    step(0, 0, 0, 0, 0, en, 5'b0, tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.rx_fifo_push = 0; bus.rx_fifo_pop = 0;
    bus.tx_fifo_push = 0; bus.tx_fifo_pop = 0;
    bus.max_drop = 0; bus.irq_en = '0; bus.status_clr = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    #1;
    check("reset.rx_lvl", 32'(bus.rx_lvl), 32'd0);
    check("reset.status", 32'(bus.status), 32'd0);
    check("reset.irq",    32'(bus.irq),    32'd0);

    // RX full table: eight pushes, overflow push, push&pop at full, clear.
    for (int i = 0; i < 8; i++)
      vt[i] = '{1,0,0,0,0, 5'b00010, 5'b0, i+1, 0,
                (i == 7) ? 5'b00010 : 5'b0, 0, 0};
    vt[8]  = '{1,0,0,0,0, 5'b00010, 5'b0,     8, 0, 5'b00010, 1, 1};
    vt[9]  = '{1,1,0,0,0, 5'b00010, 5'b0,     8, 0, 5'b00010, 1, 1};
    vt[10] = '{0,0,0,0,0, 5'b00010, 5'b00010, 8, 0, 5'b00000, 1, 1};
    vt[11] = '{0,0,0,0,0, 5'b00010, 5'b0,     8, 0, 5'b00000, 1, 0};
    for (int i = 0; i < 12; i++) begin
      step(vt[i].rp, vt[i].rpo, vt[i].tp, vt[i].tpo, vt[i].drop,
           vt[i].en, vt[i].clr, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.rx", i),  32'(bus.rx_lvl),    32'(vt[i].rx));
      check($sformatf("tbl%0d.sts", i), 32'(bus.status),    32'(vt[i].sts));
      check($sformatf("tbl%0d.err", i), 32'(bus.proto_err), 32'(vt[i].err));
      check($sformatf("tbl%0d.irq", i), 32'(bus.irq),       32'(vt[i].irq));
    end

    // Reset mid-operation: build rx_lvl=5, status=00110, irq=1.
    do_reset();
    step(1, 0, 0, 0, 0, 5'b0, 5'b0, "mid.p");
    step(0, 1, 0, 0, 0, 5'b0, 5'b0, "mid.e");
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 5'b0, 5'b0, "mid.fill");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 5'b0, 5'b0, "mid.drain");
    idle(5'b00110, "mid.en");
    check("mid.rx5",  32'(bus.rx_lvl), 32'd5);
    check("mid.sts",  32'(bus.status), 32'b00110);
    check("mid.irq1", 32'(bus.irq),    32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid.async.rx",  32'(bus.rx_lvl),    32'd0);
    check("mid.async.sts", 32'(bus.status),    32'd0);
    check("mid.async.irq", 32'(bus.irq),       32'd0);
    check("mid.async.err", 32'(bus.proto_err), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(5'b00110, "mid.post0");
    idle(5'b00110, "mid.post1");
    check("mid.post.sts", 32'(bus.status), 32'd0);

    // Simultaneous strobes at mid level and at full.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5'b0, 5'b0, "sim.fill");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 5'b0, 5'b0, "sim.pp");
    check("sim.rx3", 32'(bus.rx_lvl), 32'd3);
    check("sim.sts", 32'(bus.status), 32'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 5'b0, 5'b0, "sim.fill8");
    step(1, 1, 0, 0, 0, 5'b0, 5'b0, "sim.pp8");
    check("sim.pp8.err", 32'(bus.proto_err), 32'd0);
    check("sim.pp8.sts", 32'(bus.status),    32'b00010);

    // TX empty while masked, then unmask.
    step(0, 0, 1, 0, 0, 5'b0, 5'b11111, "txe.clr");
    step(0, 0, 0, 1, 0, 5'b0, 5'b0,     "txe.pop");
    check("txe.tx0", 32'(bus.tx_lvl), 32'd0);
    check("txe.sts", 32'(bus.status), 32'b10000);
    check("txe.irq0", 32'(bus.irq),   32'd0);
    idle(5'b10000, "txe.en");
    check("txe.irq1", 32'(bus.irq),   32'd1);

    // Set/clear collision on max_drop.
    step(0, 0, 0, 0, 1, 5'b00001, 5'b00001, "col.set");
    check("col.sts0", 32'(bus.status[STS_MAX_DROP]), 32'd1);
    step(0, 0, 0, 0, 0, 5'b00001, 5'b00001, "col.clr");
    check("col.sts0.clr", 32'(bus.status[STS_MAX_DROP]), 32'd0);
    check("col.irq.hold", 32'(bus.irq), 32'd1);
    idle(5'b00001, "col.fall");
    check("col.irq.fall", 32'(bus.irq), 32'd0);

    // Underflow.
    do_reset();
    step(0, 1, 0, 0, 0, 5'b11111, 5'b0, "unf");
    check("unf.rx0", 32'(bus.rx_lvl),    32'd0);
    check("unf.err", 32'(bus.proto_err), 32'd1);
    check("unf.sts2", 32'(bus.status[STS_RX_EMPTY]), 32'd0);

    // Randomized run against the model.
    do_reset();
    begin
      bit [4:0] en;
      en = 5'($urandom);
      for (int i = 0; i < 3000; i++) begin
        bit [4:0] clr;
        if ($urandom_range(15) == 0) en = 5'($urandom);
        clr = ($urandom_range(3) == 0) ? 5'($urandom) : 5'b0;
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(7) == 0), en, clr, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
